// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - run_ctrl state encoding and default parameters
// STEP_WAIT is present only when RUN_CTRL_STEP_EN is defined.
package run_ctrl_pkg;

  localparam int DEF_PC_W         = 32;
  localparam int DEF_CNT_W        = 32;
  localparam int DEF_RESET_CYCLES = 4;
  localparam int DEF_MAX_CYCLES   = 100000;
  localparam int DEF_STALL_LIMIT  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_HOLD,
    ST_RUN,
    ST_HALTED,
    ST_TIMEOUT
`ifdef RUN_CTRL_STEP_EN
    , ST_STEP_WAIT
`endif
  } run_state_e;

endpackage

// File: rtl/run_ctrl_if.sv
// rtl/run_ctrl_if.sv - run_ctrl control/status bundle; master drives the run requests
interface run_ctrl_if #(
  parameter int PC_W  = run_ctrl_pkg::DEF_PC_W,
  parameter int CNT_W = run_ctrl_pkg::DEF_CNT_W
);

  logic             start;
  logic             halt_req;
  logic             step;
  logic [PC_W-1:0]  pc;
  logic             core_reset;
  logic             core_en;
  logic [CNT_W-1:0] cycle_count;
  logic             done;
  logic             timeout;
  logic [PC_W-1:0]  last_pc;

  modport master (
    output start, halt_req, step, pc,
    input  core_reset, core_en, cycle_count, done, timeout, last_pc
  );

  modport slave (
    input  start, halt_req, step, pc,
    output core_reset, core_en, cycle_count, done, timeout, last_pc
  );

endinterface

// File: rtl/run_ctrl_stall_detect.sv
// rtl/run_ctrl_stall_detect.sv - pc-unchanged counter; pulses stall on the STALL_LIMIT-th identical cycle
module stall_detect
  import run_ctrl_pkg::*;
#(
  parameter int PC_W        = DEF_PC_W,
  parameter int STALL_LIMIT = DEF_STALL_LIMIT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            en,
  input  logic [PC_W-1:0] pc,
  output logic            stall
);

  localparam int SW = $clog2(STALL_LIMIT);

  logic [PC_W-1:0] prev_pc;
  logic            prev_vld;
  logic [SW-1:0]   cnt;
  logic            same;

  // the first enabled cycle after a clear has nothing to compare against
  assign same  = prev_vld && (pc == prev_pc);
  assign stall = en && same && (cnt == SW'(STALL_LIMIT - 2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_pc  <= '0;
      prev_vld <= 1'b0;
      cnt      <= '0;
    end else if (clr) begin
      prev_vld <= 1'b0;
      cnt      <= '0;
    end else if (en) begin
      prev_pc  <= pc;
      prev_vld <= 1'b1;
      if (!same)
        cnt <= '0;
      else if (cnt != SW'(STALL_LIMIT - 1))
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - core run controller: reset hold, run, halt/stall/timeout detection
// Optional single-step mode under RUN_CTRL_STEP_EN.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int PC_W         = DEF_PC_W,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
  parameter int STALL_LIMIT  = DEF_STALL_LIMIT
) (
  input  logic       clk,
  input  logic       reset,
  run_ctrl_if.slave  bus
);

  localparam int RW = $clog2(RESET_CYCLES + 1);

  run_state_e       state, state_nx;
  logic [RW-1:0]    rst_cnt;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [PC_W-1:0]  last_pc_q;
  logic             clr, run_en, hold_rst;
  logic             stall, halt_ev, hit_to;

  assign cnt_inc = (&cycle_cnt) ? cycle_cnt : cycle_cnt + 1'b1;
  assign hit_to  = (cnt_inc == CNT_W'(MAX_CYCLES - 1));
  assign halt_ev = bus.halt_req | stall;

  stall_detect #(
    .PC_W        (PC_W),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stall (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (run_en),
    .pc    (bus.pc),
    .stall (stall)
  );

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    run_en   = 1'b0;
    hold_rst = 1'b0;
    case (state)
      ST_IDLE: begin
        hold_rst = 1'b1;
        if (bus.start) begin
          state_nx = ST_RST_HOLD;
          clr      = 1'b1;
        end
      end
      ST_RST_HOLD: begin
        hold_rst = 1'b1;
        if (rst_cnt == RW'(RESET_CYCLES - 1))
`ifdef RUN_CTRL_STEP_EN
          state_nx = ST_STEP_WAIT;
`else
          state_nx = ST_RUN;
`endif
      end
      ST_RUN: begin
        run_en = 1'b1;
        // halt has priority over a coincident timeout
        if (halt_ev)
          state_nx = ST_HALTED;
        else if (hit_to)
          state_nx = ST_TIMEOUT;
`ifdef RUN_CTRL_STEP_EN
        else
          state_nx = ST_STEP_WAIT;
`endif
      end
`ifdef RUN_CTRL_STEP_EN
      ST_STEP_WAIT: begin
        if (bus.step)
          state_nx = ST_RUN;
      end
`endif
      ST_HALTED, ST_TIMEOUT: begin
        if (bus.start) begin
          state_nx = ST_RST_HOLD;
          clr      = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      rst_cnt   <= '0;
      cycle_cnt <= '0;
      last_pc_q <= '0;
    end else begin
      state <= state_nx;
      if (clr) begin
        rst_cnt   <= '0;
        cycle_cnt <= '0;
        last_pc_q <= '0;
      end else if (state == ST_RST_HOLD) begin
        rst_cnt <= rst_cnt + 1'b1;
      end
      if (run_en) begin
        cycle_cnt <= cnt_inc;
        if (state_nx == ST_HALTED || state_nx == ST_TIMEOUT)
          last_pc_q <= bus.pc;
      end
    end
  end

  assign bus.core_reset  = hold_rst;
  assign bus.core_en     = run_en;
  assign bus.cycle_count = cycle_cnt;
  assign bus.done        = (state == ST_HALTED);
  assign bus.timeout     = (state == ST_TIMEOUT);
  assign bus.last_pc     = last_pc_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb/tb_run_ctrl.sv - directed self-checking bench for run_ctrl (MAX_CYCLES=20)
module tb_run_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  run_ctrl_if #(.PC_W(32), .CNT_W(32)) bus ();

  run_ctrl #(
    .PC_W         (32),
    .CNT_W        (32),
    .RESET_CYCLES (4),
    .MAX_CYCLES   (20),
    .STALL_LIMIT  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    next_cycle;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.halt_req = 1'b0;
    bus.step     = 1'b0;
    bus.pc       = '0;
    #2;
    reset = 1'b1;
  endtask

  task automatic do_start;
    bus.start = 1'b1;
    next_cycle;
    bus.start = 1'b0;
  endtask

  task automatic to_run;
    do_reset;
    do_start;
    repeat (4) next_cycle;
  endtask

  task automatic test_reset;
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.halt_req = 1'b0;
    bus.step     = 1'b0;
    bus.pc       = '0;
    #12;
    @(negedge clk);
    checks++;
    if ({bus.core_reset, bus.core_en, bus.done, bus.timeout} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=1000", {bus.core_reset, bus.core_en, bus.done, bus.timeout});
    end
    checks++;
    if (bus.cycle_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_count got=%0d exp=0", bus.cycle_count);
    end
    checks++;
    if (bus.last_pc !== 32'd0) begin
      failures++;
      $display("FAIL reset_last_pc got=%h exp=0", bus.last_pc);
    end
    reset = 1'b1;
    repeat (3) next_cycle;
    @(negedge clk);
    checks++;
    if ({bus.core_reset, bus.core_en} !== 2'b10) begin
      failures++;
      $display("FAIL idle_hold got=%b exp=10", {bus.core_reset, bus.core_en});
    end
  endtask

  task automatic test_startup;
    do_reset;
    do_start;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.core_reset, bus.core_en} !== 2'b10) begin
        failures++;
        $display("FAIL rst_hold_%0d got=%b exp=10", i, {bus.core_reset, bus.core_en});
      end
      next_cycle;
    end
    for (int k = 0; k < 4; k++) begin
      bus.pc = 32'h100 + 32'(4 * k);
      @(negedge clk);
      checks++;
      if (bus.core_en !== 1'b1 || bus.core_reset !== 1'b0 || bus.cycle_count !== 32'(k)) begin
        failures++;
        $display("FAIL run_count_%0d got en=%b rst=%b cnt=%0d exp en=1 rst=0 cnt=%0d",
                 k, bus.core_en, bus.core_reset, bus.cycle_count, k);
      end
      next_cycle;
    end
  endtask

  task automatic test_halt;
    to_run;
    for (int k = 0; k <= 10; k++) begin
      bus.pc       = 32'h100 + 32'(4 * k);
      bus.halt_req = (k == 10);
      bus.start    = (k == 5);
      @(negedge clk);
      if (k == 6) begin
        checks++;
        if (bus.core_en !== 1'b1 || bus.cycle_count !== 32'd6) begin
          failures++;
          $display("FAIL start_ignored got en=%b cnt=%0d exp en=1 cnt=6", bus.core_en, bus.cycle_count);
        end
      end
      if (k == 10) begin
        checks++;
        if (bus.cycle_count !== 32'd10) begin
          failures++;
          $display("FAIL halt_pre_count got=%0d exp=10", bus.cycle_count);
        end
      end
      next_cycle;
    end
    bus.halt_req = 1'b0;
    bus.start    = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.done, bus.timeout, bus.core_en} !== 3'b100) begin
      failures++;
      $display("FAIL halt_flags got=%b exp=100", {bus.done, bus.timeout, bus.core_en});
    end
    checks++;
    if (bus.cycle_count !== 32'd11) begin
      failures++;
      $display("FAIL halt_count got=%0d exp=11", bus.cycle_count);
    end
    checks++;
    if (bus.last_pc !== 32'h128) begin
      failures++;
      $display("FAIL halt_last_pc got=%h exp=128", bus.last_pc);
    end
    repeat (3) next_cycle;
    bus.pc = 32'h999;
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.cycle_count !== 32'd11 || bus.last_pc !== 32'h128) begin
      failures++;
      $display("FAIL halt_sticky got done=%b cnt=%0d pc=%h exp done=1 cnt=11 pc=128",
               bus.done, bus.cycle_count, bus.last_pc);
    end
  endtask

  task automatic test_stall;
    to_run;
    for (int k = 0; k <= 12; k++) begin
      bus.pc = (k < 5) ? 32'h100 + 32'(4 * k) : 32'h40;
      @(negedge clk);
      if (k == 12) begin
        checks++;
        if (bus.core_en !== 1'b1 || bus.done !== 1'b0) begin
          failures++;
          $display("FAIL stall_early got en=%b done=%b exp en=1 done=0", bus.core_en, bus.done);
        end
      end
      next_cycle;
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.core_en !== 1'b0) begin
      failures++;
      $display("FAIL stall_done got done=%b en=%b exp done=1 en=0", bus.done, bus.core_en);
    end
    checks++;
    if (bus.cycle_count !== 32'd13 || bus.last_pc !== 32'h40) begin
      failures++;
      $display("FAIL stall_state got cnt=%0d pc=%h exp cnt=13 pc=40", bus.cycle_count, bus.last_pc);
    end
  endtask

  task automatic test_timeout;
    to_run;
    for (int k = 0; k <= 18; k++) begin
      bus.pc = 32'h200 + 32'(4 * k);
      @(negedge clk);
      if (k == 18) begin
        checks++;
        if (bus.core_en !== 1'b1 || bus.cycle_count !== 32'd18) begin
          failures++;
          $display("FAIL timeout_pre got en=%b cnt=%0d exp en=1 cnt=18", bus.core_en, bus.cycle_count);
        end
      end
      next_cycle;
    end
    @(negedge clk);
    checks++;
    if ({bus.timeout, bus.done, bus.core_en} !== 3'b100) begin
      failures++;
      $display("FAIL timeout_flags got=%b exp=100", {bus.timeout, bus.done, bus.core_en});
    end
    checks++;
    if (bus.cycle_count !== 32'd19 || bus.last_pc !== 32'h248) begin
      failures++;
      $display("FAIL timeout_state got cnt=%0d pc=%h exp cnt=19 pc=248", bus.cycle_count, bus.last_pc);
    end
    do_start;
    @(negedge clk);
    checks++;
    if ({bus.timeout, bus.done, bus.core_reset} !== 3'b001 || bus.cycle_count !== 32'd0) begin
      failures++;
      $display("FAIL timeout_restart got flags=%b cnt=%0d exp flags=001 cnt=0",
               {bus.timeout, bus.done, bus.core_reset}, bus.cycle_count);
    end
  endtask

  task automatic test_halt_vs_timeout;
    to_run;
    for (int k = 0; k <= 18; k++) begin
      bus.pc       = 32'h200 + 32'(4 * k);
      bus.halt_req = (k == 18);
      next_cycle;
    end
    bus.halt_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.done, bus.timeout} !== 2'b10) begin
      failures++;
      $display("FAIL halt_wins got done/timeout=%b exp=10", {bus.done, bus.timeout});
    end
    checks++;
    if (bus.cycle_count !== 32'd19 || bus.last_pc !== 32'h248) begin
      failures++;
      $display("FAIL halt_wins_state got cnt=%0d pc=%h exp cnt=19 pc=248", bus.cycle_count, bus.last_pc);
    end
  endtask

  task automatic test_async_reset;
    to_run;
    for (int k = 0; k < 6; k++) begin
      bus.pc = 32'h300 + 32'(4 * k);
      next_cycle;
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.core_reset, bus.core_en, bus.done, bus.timeout} !== 4'b1000 || bus.cycle_count !== 32'd0) begin
      failures++;
      $display("FAIL async_reset got flags=%b cnt=%0d exp flags=1000 cnt=0",
               {bus.core_reset, bus.core_en, bus.done, bus.timeout}, bus.cycle_count);
    end
    repeat (2) next_cycle;
    reset = 1'b1;
    repeat (3) next_cycle;
    @(negedge clk);
    checks++;
    if ({bus.core_reset, bus.core_en, bus.done, bus.timeout} !== 4'b1000) begin
      failures++;
      $display("FAIL async_no_flag got=%b exp=1000", {bus.core_reset, bus.core_en, bus.done, bus.timeout});
    end
    do_start;
    repeat (4) next_cycle;
    for (int k = 0; k < 3; k++) begin
      bus.pc = 32'h500 + 32'(4 * k);
      @(negedge clk);
      checks++;
      if (bus.core_en !== 1'b1 || bus.cycle_count !== 32'(k)) begin
        failures++;
        $display("FAIL rerun_%0d got en=%b cnt=%0d exp en=1 cnt=%0d", k, bus.core_en, bus.cycle_count, k);
      end
      next_cycle;
    end
  endtask

  task automatic test_step_ignored;
    to_run;
    for (int k = 0; k < 6; k++) begin
      bus.pc   = 32'h600 + 32'(4 * k);
      bus.step = (k == 2);
      next_cycle;
    end
    bus.step = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.core_en !== 1'b1 || bus.cycle_count !== 32'd6) begin
      failures++;
      $display("FAIL step_ignored got en=%b cnt=%0d exp en=1 cnt=6", bus.core_en, bus.cycle_count);
    end
  endtask

  task automatic test_step;
    int en_hi;
    do_reset;
    do_start;
    repeat (4) next_cycle;
    en_hi = 0;
    for (int i = 0; i < 20; i++) begin
      bus.pc   = 32'h400 + 32'(4 * i);
      bus.step = (i == 2 || i == 7 || i == 12);
      @(negedge clk);
      en_hi = en_hi + int'(bus.core_en);
      next_cycle;
    end
    bus.step = 1'b0;
    @(negedge clk);
    checks++;
    if (en_hi != 3) begin
      failures++;
      $display("FAIL step_pulses got=%0d exp=3", en_hi);
    end
    checks++;
    if (bus.cycle_count !== 32'd3 || bus.core_en !== 1'b0) begin
      failures++;
      $display("FAIL step_count got cnt=%0d en=%b exp cnt=3 en=0", bus.cycle_count, bus.core_en);
    end
  endtask

  initial begin
    test_reset;
`ifdef RUN_CTRL_STEP_EN
    test_step;
`else
    test_startup;
    test_halt;
    test_stall;
    test_timeout;
    test_halt_vs_timeout;
    test_async_reset;
    test_step_ignored;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter PC_W, default 32: width of the monitored program counter.
REQ-002 Parameter CNT_W, default 32: width of the cycle counter.
REQ-003 Parameter RESET_CYCLES, default 4: core-reset hold length in cycles, at least 1.
REQ-004 Parameter MAX_CYCLES, default 100000: timeout limit, at most 2^CNT_W-1.
REQ-005 Parameter STALL_LIMIT, default 8: consecutive unchanged-PC cycles that count as halt, at least 2.
REQ-006 clk  in  1  single system clock; all state updates on the rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  one-cycle pulse that begins a run from IDLE.
REQ-009 halt_req  in  1  core reports a halt instruction.
REQ-010 pc  in  PC_W  current core program counter.
REQ-011 step  in  1  single-step pulse; used only with RUN_CTRL_STEP_EN.
REQ-012 core_reset  out  1  active-high reset to the core.
REQ-013 core_en  out  1  core clock-enable.
REQ-014 cycle_count  out  CNT_W  number of enabled core cycles in the current run.
REQ-015 done  out  1  run ended by halt; sticky.
REQ-016 timeout  out  1  run ended by MAX_CYCLES; sticky.
REQ-017 last_pc  out  PC_W  pc captured at the end of the run.

Function
REQ-018 States: IDLE, RST_HOLD, RUN, HALTED, TIMEOUT, plus STEP_WAIT when RUN_CTRL_STEP_EN is defined.
REQ-019 IDLE: core_reset=1, core_en=0; on start go to RST_HOLD, clear cycle_count, done, timeout and the stall counter.
REQ-020 RST_HOLD: core_reset=1 for exactly RESET_CYCLES cycles, then go to RUN.
REQ-021 RUN: core_reset=0, core_en=1; cycle_count increments by 1 every RUN cycle.
REQ-022 Stall counter: increments when pc equals the previous cycle's pc; clears otherwise.
REQ-023 Halt: halt_req=1, or the stall counter reaching STALL_LIMIT-1, moves RUN to HALTED on the next edge.
REQ-024 In HALTED: done=1, core_en=0, last_pc=pc from the final RUN cycle.
REQ-025 Timeout: when cycle_count reaches MAX_CYCLES-1 in RUN, go to TIMEOUT; timeout=1, core_en=0, last_pc captured.
REQ-026 If halt and timeout occur in the same cycle, halt wins: done=1, timeout=0.
REQ-027 HALTED and TIMEOUT hold until start, which re-enters RST_HOLD and clears all flags and counters.
REQ-028 start is ignored in RST_HOLD, RUN and STEP_WAIT.
REQ-029 cycle_count saturates at 2^CNT_W-1 and never wraps.

Reset
REQ-030 Asserting reset (low) at any time forces IDLE immediately, regardless of clk.
REQ-031 Reset values: core_reset=1, core_en=0, cycle_count=0, done=0, timeout=0, last_pc=0.
REQ-032 Reset asserted mid-run discards the run; no done or timeout flag is produced.

Configuration
REQ-033 With RUN_CTRL_STEP_EN defined, RST_HOLD exits to STEP_WAIT instead of RUN.
REQ-034 STEP_WAIT: core_en=0; each step pulse gives one RUN cycle (core_en=1 for exactly one cycle, cycle_count+1), then returns to STEP_WAIT.
REQ-035 Halt and timeout checks apply during single-step cycles exactly as in RUN.
REQ-036 Without RUN_CTRL_STEP_EN, the step input is ignored and STEP_WAIT logic is not synthesised.

Structure
REQ-037 Shared package run_ctrl_pkg holds the state enum typedef and the default parameter constants.
REQ-038 Sub-module stall_detect holds the pc register, pc compare and stall counter, and outputs a stall pulse.

Verification
REQ-039 Reset low, then high, then start: core_reset=1 for exactly 4 cycles, then core_en=1 and cycle_count counts 1, 2, 3, and so on.
REQ-040 halt_req pulse at cycle_count=10: done=1, core_en=0 on the next edge, cycle_count holds at 11, last_pc equals the pc of that cycle.
REQ-041 pc frozen at 0x40 from cycle 5: done=1 after 8 identical cycles, last_pc=0x40.
REQ-042 MAX_CYCLES=20 with pc incrementing: timeout=1 and done=0 at cycle_count=19; halt_req at that same cycle gives done=1 and timeout=0.
REQ-043 Reset low during RUN: outputs return to reset values asynchronously, and a following start re-runs cleanly.
REQ-044 RUN_CTRL_STEP_EN defined, three step pulses: exactly 3 one-cycle core_en pulses and cycle_count=3.
